counter_updn_mod: RTL and testbench
===================================

// Module: counter_updn_mod
// PURPOSE
//  Parametrised up/down counter with programmable terminal value (modulus), wrap or
//  saturate mode, count enable, parallel load, and one-cycle wrap/saturation pulses.
//  Next generation of the team's simple up/down counter. Used as an event/timer
//  counter in datapath control, where software sets the limit and the mode at run time.
// PARAMETERS
//  WIDTH   4  counter, data and limit width in bits (>=2)
//  PRE_W   4  prescaler width in bits; used only when CNT_PRESCALE_EN is defined
// PORTS
//  clk        in   1        rising-edge clock
//  reset      in   1        synchronous, active-high reset
//  en         in   1        count enable (qualifies up/down steps only)
//  load       in   1        parallel load request
//  data       in   WIDTH    load value
//  up_dwn     in   1        1 = count up, 0 = count down
//  limit      in   WIDTH    terminal value; the count range is 0..limit
//  sat_mode   in   1        1 = saturate at range ends, 0 = wrap
//  prescale   in   PRE_W    step every prescale+1 enabled cycles (CNT_PRESCALE_EN only)
//  out        out  WIDTH    current count (registered)
//  at_max     out  1        combinational: out == limit
//  at_zero    out  1        combinational: out == 0
//  wrap       out  1        registered pulse: the last step wrapped
//  sat        out  1        registered pulse: the last step was blocked by saturation
// BEHAVIOUR
//  - All state updates on posedge clk. Priority: reset > load > en step > hold.
//  - reset: out=0, wrap=0, sat=0, prescaler divider=0. A reset during counting
//    overrides all other inputs in that cycle.
//  - load: out <= (data > limit) ? limit : data. wrap=0, sat=0, divider=0.
//    en and up_dwn are ignored in the load cycle.
//  - Step (en=1, no load; with prescaler, only in a cycle where divider == prescale):
//    up, out <  limit  -> out+1
//    up, out >= limit  -> wrap mode: out=0, wrap=1;  sat mode: out=limit, sat=1
//    dn, out >  0      -> out-1; if out > limit, out=limit (clamp; no pulse)
//    dn, out == 0      -> wrap mode: out=limit, wrap=1; sat mode: out=0, sat=1
//  - wrap and sat are high for exactly one cycle, the cycle after the step that caused
//    them. Both are 0 in every other cycle, including hold and load cycles. They are
//    never high at the same time.
//  - en=0: out and the divider hold. wrap and sat go to 0.
//  - limit may change at any time. It takes effect on the next step. out > limit is
//    legal until the next step or load resolves it as above.
//  - limit=0: every up or down step in wrap mode gives out=0 with wrap=1. In sat mode
//    it gives out=0 with sat=1.
//  - sat_mode and up_dwn are sampled only in step cycles; no latency beyond one cycle.
//  - Arithmetic is unsigned, WIDTH bits. No carry out of bit WIDTH-1 is ever produced
//    (range checks precede increment/decrement).
// CONFIGURATION
//  CNT_PRESCALE_EN defined: a PRE_W-bit divider counts en=1 cycles from 0 to prescale.
//    A step occurs on the cycle it equals prescale, and the divider then returns to 0.
//    The divider holds when en=0 and clears on reset or load. prescale=0 means a step
//    on every enabled cycle. If prescale drops below the divider, the divider returns
//    to 0 without stepping.
//  CNT_PRESCALE_EN undefined: there is no prescale port and no divider. Every en=1
//    cycle is a step cycle.
// TESTING  (WIDTH=4)
//  reset=1 for 2 cycles with load=1, data=9 -> out=0, wrap=0, sat=0, at_zero=1
//  limit=9, wrap mode, load 7, up x3 -> out 8,9,0; wrap=1 only in the cycle after 9->0
//  limit=9, sat mode, out=0, down x2 -> out stays 0; sat=1 for 2 cycles; at_zero=1
//  out=12, limit=5, load data=14 -> out=5; then down step -> out=4, no pulse
//  load=1 and en=1 in the same cycle, data=3 -> out=3, no step taken; reset mid-count -> out=0
//  CNT_PRESCALE_EN, prescale=2, en held, up from 0 -> out steps every 3rd cycle: 1,2,3

Source files
------------

// File: rtl/counter_updn_mod_if.sv
// Counter control/status bundle: master drives control, slave returns count and flags.
// CNT_PRESCALE_EN adds the PRE_W parameter and the prescale field.
interface counter_updn_mod_if #(
  parameter int WIDTH = 4
`ifdef CNT_PRESCALE_EN
  , parameter int PRE_W = 4
`endif
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] data;
  logic             up_dwn;
  logic [WIDTH-1:0] limit;
  logic             sat_mode;
`ifdef CNT_PRESCALE_EN
  logic [PRE_W-1:0] prescale;
`endif
  logic [WIDTH-1:0] out;
  logic             at_max;
  logic             at_zero;
  logic             wrap;
  logic             sat;

  modport master (
    output en, load, data, up_dwn, limit, sat_mode,
`ifdef CNT_PRESCALE_EN
    output prescale,
`endif
    input  out, at_max, at_zero, wrap, sat
  );

  modport slave (
    input  en, load, data, up_dwn, limit, sat_mode,
`ifdef CNT_PRESCALE_EN
    input  prescale,
`endif
    output out, at_max, at_zero, wrap, sat
  );
endinterface

// File: rtl/counter_updn_mod.sv
// Up/down counter, range 0..limit, wrap or saturate, load, wrap/sat pulses.
// Ports: clk, reset (sync, active high), bus (slave). Macro CNT_PRESCALE_EN adds a step divider.
module counter_updn_mod #(
  parameter int WIDTH = 4,
  parameter int PRE_W = 4
) (
  input  logic          clk,
  input  logic          reset,
  counter_updn_mod_if.slave bus
);
  logic [WIDTH-1:0] cnt;
  logic             wrap_q;
  logic             sat_q;
  logic             step;

`ifdef CNT_PRESCALE_EN
  logic [PRE_W-1:0] div;

  always_comb step = bus.en && (div == bus.prescale);

  // Divider also resets when prescale drops below it (no step then).
  always_ff @(posedge clk) begin
    if (reset || bus.load) begin
      div <= '0;
    end else if (bus.en) begin
      if (div >= bus.prescale) div <= '0;
      else                     div <= div + 1'b1;
    end
  end
`else
  logic [PRE_W-1:0] unused_pre;
  assign unused_pre = '0;

  always_comb step = bus.en;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else if (bus.load) begin
      cnt    <= (bus.data > bus.limit) ? bus.limit : bus.data;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
      if (step) begin
        if (bus.up_dwn) begin
          if (cnt < bus.limit) begin
            cnt <= cnt + 1'b1;
          end else if (bus.sat_mode) begin
            cnt   <= bus.limit;
            sat_q <= 1'b1;
          end else begin
            cnt    <= '0;
            wrap_q <= 1'b1;
          end
        end else begin
          if (cnt == '0) begin
            if (bus.sat_mode) begin
              sat_q <= 1'b1;
            end else begin
              cnt    <= bus.limit;
              wrap_q <= 1'b1;
            end
          end else if (cnt > bus.limit) begin
            // Stale count above a lowered limit snaps to limit.
            cnt <= bus.limit;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      end
    end
  end

  assign bus.out     = cnt;
  assign bus.at_max  = (cnt == bus.limit);
  assign bus.at_zero = (cnt == '0);
  assign bus.wrap    = wrap_q;
  assign bus.sat     = sat_q;
endmodule

// File: tb/tb_counter_updn_mod.sv
// Scoreboard bench for counter_updn_mod (WIDTH=4).
// Expected state is pushed when inputs are driven, popped after the edge.
module tb_counter_updn_mod;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

`ifdef CNT_PRESCALE_EN
  counter_updn_mod_if #(.WIDTH(4), .PRE_W(4)) bus ();
`else
  counter_updn_mod_if #(.WIDTH(4)) bus ();
`endif

  counter_updn_mod #(.WIDTH(4), .PRE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] out;
    logic       w;
    logic       s;
    logic       mx;
    logic       z;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         fails  = 0;
  logic [3:0] m_out  = 4'd0;
  logic [3:0] m_div  = 4'd0;
  logic [3:0] pre    = 4'd0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit ld, input bit e,
                     input bit ud, input bit sm,
                     input logic [3:0] d, input logic [3:0] lim);
    exp_t x;
    bit   st;
    reset        = r;
    bus.load     = ld;
    bus.en       = e;
    bus.up_dwn   = ud;
    bus.sat_mode = sm;
    bus.data     = d;
    bus.limit    = lim;
`ifdef CNT_PRESCALE_EN
    bus.prescale = pre;
`endif
    x.w = 1'b0;
    x.s = 1'b0;
    x.out = m_out;
    st = 1'b0;
    if (r) begin
      x.out = 4'd0;
      m_div = 4'd0;
    end else if (ld) begin
      x.out = (d > lim) ? lim : d;
      m_div = 4'd0;
    end else if (e) begin
`ifdef CNT_PRESCALE_EN
      if (m_div == pre) begin st = 1'b1; m_div = 4'd0; end
      else if (m_div > pre) m_div = 4'd0;
      else m_div = m_div + 4'd1;
`else
      st = 1'b1;
`endif
    end
    if (st) begin
      if (ud) begin
        if (m_out < lim) x.out = m_out + 4'd1;
        else if (sm) begin x.out = lim; x.s = 1'b1; end
        else begin x.out = 4'd0; x.w = 1'b1; end
      end else if (m_out == 4'd0) begin
        if (sm) x.s = 1'b1;
        else begin x.out = lim; x.w = 1'b1; end
      end else if (m_out > lim) begin
        x.out = lim;
      end else begin
        x.out = m_out - 4'd1;
      end
    end
    m_out = x.out;
    x.mx = (x.out == lim);
    x.z  = (x.out == 4'd0);
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("out",     int'(bus.out),     int'(x.out));
    chk("wrap",    int'(bus.wrap),    int'(x.w));
    chk("sat",     int'(bus.sat),     int'(x.s));
    chk("at_max",  int'(bus.at_max),  int'(x.mx));
    chk("at_zero", int'(bus.at_zero), int'(x.z));
    chk("excl",    int'(bus.wrap & bus.sat), 0);
  endtask

  initial begin
    // reset held 2 cycles with load request
    cyc(1, 1, 0, 1, 0, 4'd9, 4'd9);
    cyc(1, 1, 0, 1, 0, 4'd9, 4'd9);
    chk("rst_out", int'(bus.out), 0);
    chk("rst_zero", int'(bus.at_zero), 1);

    // wrap mode: load 7, up x3 -> 8, 9, 0 (wrap)
    cyc(0, 1, 0, 0, 0, 4'd7, 4'd9);
    cyc(0, 0, 1, 1, 0, 4'd0, 4'd9);
    chk("up8", int'(bus.out), 8);
    cyc(0, 0, 1, 1, 0, 4'd0, 4'd9);
    chk("up9", int'(bus.out), 9);
    chk("up9_w", int'(bus.wrap), 0);
    cyc(0, 0, 1, 1, 0, 4'd0, 4'd9);
    chk("wrap0", int'(bus.out), 0);
    chk("wrap_p", int'(bus.wrap), 1);
    cyc(0, 0, 0, 1, 0, 4'd0, 4'd9);
    chk("wrap_1c", int'(bus.wrap), 0);

    // sat mode at 0, down x2
    cyc(0, 0, 1, 0, 1, 4'd0, 4'd9);
    chk("sat1", int'(bus.sat), 1);
    cyc(0, 0, 1, 0, 1, 4'd0, 4'd9);
    chk("sat2", int'(bus.sat), 1);
    chk("sat_out", int'(bus.out), 0);

    // wrap down from 0 -> limit
    cyc(0, 0, 1, 0, 0, 4'd0, 4'd9);
    chk("dnwrap", int'(bus.out), 9);

    // out above lowered limit, load clamps, then down
    cyc(0, 1, 0, 0, 0, 4'd12, 4'd15);
    cyc(0, 0, 0, 0, 0, 4'd0, 4'd5);
    chk("stale", int'(bus.out), 12);
    cyc(0, 1, 0, 0, 0, 4'd14, 4'd5);
    chk("ldclamp", int'(bus.out), 5);
    cyc(0, 0, 1, 0, 0, 4'd0, 4'd5);
    chk("dn4", int'(bus.out), 4);

    // down step clamps stale count to limit
    cyc(0, 1, 0, 0, 0, 4'd12, 4'd15);
    cyc(0, 0, 1, 0, 0, 4'd0, 4'd5);
    chk("dnclamp", int'(bus.out), 5);

    // sat at top
    cyc(0, 0, 1, 1, 1, 4'd0, 4'd5);
    chk("sattop", int'(bus.out), 5);

    // load beats en
    cyc(0, 1, 1, 1, 0, 4'd3, 4'd9);
    chk("ld_en", int'(bus.out), 3);

    // limit 0
    cyc(0, 1, 0, 0, 0, 4'd0, 4'd0);
    cyc(0, 0, 1, 1, 0, 4'd0, 4'd0);
    chk("l0_w", int'(bus.wrap), 1);
    cyc(0, 0, 1, 0, 1, 4'd0, 4'd0);
    chk("l0_s", int'(bus.sat), 1);

    // reset mid-count overrides load/en
    cyc(0, 1, 0, 0, 0, 4'd4, 4'd9);
    cyc(0, 0, 1, 1, 0, 4'd0, 4'd9);
    cyc(1, 1, 1, 1, 0, 4'd7, 4'd9);
    chk("rst_mid", int'(bus.out), 0);

`ifdef CNT_PRESCALE_EN
    pre = 4'd2;
    cyc(0, 1, 0, 0, 0, 4'd0, 4'd9);
    for (int i = 0; i < 9; i++) cyc(0, 0, 1, 1, 0, 4'd0, 4'd9);
    chk("pre3", int'(bus.out), 3);
    pre = 4'd0;
`endif

    for (int i = 0; i < 300; i++) begin
`ifdef CNT_PRESCALE_EN
      pre = 4'($urandom_range(0, 3));
`endif
      cyc(($urandom_range(0, 40) == 0),
          ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 3) != 0),
          1'($urandom),
          1'($urandom),
          4'($urandom),
          4'($urandom));
    end

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
